// File: rtl/conv_layer_seq_pkg.sv
// Shared types and constants for the convolution layer sequencer.
// Holds the FSM state encoding and the default kernel geometry.
package conv_layer_seq_pkg;

  localparam int unsigned KERNEL_SIZE_DFLT = 3;
  localparam int unsigned KK               = KERNEL_SIZE_DFLT * KERNEL_SIZE_DFLT;
  localparam int unsigned CNT_W            = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_STREAM,
    S_DRAIN,
    S_FIN
  } seq_state_e;

endpackage

// File: rtl/conv_layer_seq_if.sv
// Control and PE-array-side signal bundle of the convolution layer sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface conv_layer_seq_if #(
  parameter int unsigned PASS_W = 6
);
  logic              start;
  logic [4:0]        cfg_featmap_size;
  logic [PASS_W-1:0] cfg_num_passes;
  logic              cfg_bias_mode;
  logic              pe_dout_st;
  logic              busy;
  logic              done;
  logic              err;
  logic              win_st;
  logic              w_rd_en;
  logic              din_st;
  logic              d_rd_en;
  logic [4:0]        featmap_size;
  logic              convlayer_state;
  logic [PASS_W-1:0] pass_idx;
  logic              out_valid;
  logic [4:0]        out_row;
  logic [4:0]        out_col;

  modport slave (
    input  start, cfg_featmap_size, cfg_num_passes, cfg_bias_mode, pe_dout_st,
    output busy, done, err, win_st, w_rd_en, din_st, d_rd_en, featmap_size,
           convlayer_state, pass_idx, out_valid, out_row, out_col
  );

  modport master (
    output start, cfg_featmap_size, cfg_num_passes, cfg_bias_mode, pe_dout_st,
    input  busy, done, err, win_st, w_rd_en, din_st, d_rd_en, featmap_size,
           convlayer_state, pass_idx, out_valid, out_row, out_col
  );

endinterface

// File: rtl/conv_layer_seq_tracker.sv
// Raster-position tracker for the PE output stream of one pass.
// Flags which samples are complete convolution windows and reports when the map is done.
module conv_out_tracker
  import conv_layer_seq_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE = KERNEL_SIZE_DFLT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       pe_dout_st,
  input  logic [4:0] fm,
  output logic       out_valid,
  output logic [4:0] out_row,
  output logic [4:0] out_col,
  output logic       finished
);

  logic       run_q, run_d;
  logic       fin_q, fin_d;
  logic [4:0] r_q, r_d;
  logic [4:0] c_q, c_d;
  logic       valid_q, valid_d;
  logic [4:0] row_q, row_d;
  logic [4:0] col_q, col_d;

  logic       pos_ok;
  logic [4:0] pr, pc;
  logic [4:0] fm_last, lim;

  assign fm_last = fm - 5'd1;
  assign lim     = fm - 5'(KERNEL_SIZE);

  // The position handled this cycle is (0,0) on the start cycle, else the running counters;
  // results land in the output flops one cycle later, in step with the PE's registered dout.
  always_comb begin
    run_d   = run_q;
    fin_d   = fin_q;
    r_d     = r_q;
    c_d     = c_q;
    pos_ok  = 1'b0;
    pr      = '0;
    pc      = '0;
    if (clr) begin
      run_d = 1'b0;
      fin_d = 1'b0;
      r_d   = '0;
      c_d   = '0;
    end else if (run_q || (en && !fin_q && pe_dout_st)) begin
      pos_ok = 1'b1;
      pr     = run_q ? r_q : '0;
      pc     = run_q ? c_q : '0;
      run_d  = 1'b1;
      r_d    = pr;
      if (pc == fm_last) begin
        c_d = '0;
        if (pr == fm_last) begin
          run_d = 1'b0;
          fin_d = 1'b1;
          r_d   = '0;
        end else begin
          r_d = pr + 5'd1;
        end
      end else begin
        c_d = pc + 5'd1;
      end
    end
    valid_d = pos_ok && (pr <= lim) && (pc <= lim);
    row_d   = pos_ok ? pr : row_q;
    col_d   = pos_ok ? pc : col_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q   <= 1'b0;
      fin_q   <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      valid_q <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      run_q   <= run_d;
      fin_q   <= fin_d;
      r_q     <= r_d;
      c_q     <= c_d;
      valid_q <= valid_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  assign out_valid = valid_q;
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign finished  = fin_q;

endmodule

// File: rtl/conv_layer_seq.sv
// Convolution layer sequencer: per pass loads weights, streams the feature map,
// then waits for the PE output stream to drain; repeats for the configured passes.
module conv_layer_seq
  import conv_layer_seq_pkg::*;
#(
  parameter int unsigned KERNEL_SIZE  = KERNEL_SIZE_DFLT,
  parameter int unsigned PASS_W       = 6,
  parameter int unsigned TIMEOUT_MULT = 2
) (
  input  logic           clk,
  input  logic           rst,
  conv_layer_seq_if.slave bus
);

  localparam int unsigned WD_W     = 11 + $clog2(TIMEOUT_MULT);
  localparam int unsigned LOAD_LEN = KERNEL_SIZE * KERNEL_SIZE;
  localparam logic [CNT_W-1:0] LOAD_LAST = CNT_W'(LOAD_LEN - 1);

  seq_state_e        state_q, state_d;
  logic [4:0]        fm_q, fm_d;
  logic [PASS_W-1:0] last_q, last_d;
  logic              cls_q, cls_d;
  logic              err_q, err_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WD_W-1:0]   wd_q, wd_d;

  logic [CNT_W-1:0]  area;
  logic [CNT_W-1:0]  stream_last;
  logic [WD_W-1:0]   wd_last;
  logic              too_small;
  logic              trk_clr;
  logic              trk_en;
  logic              trk_done;

  assign area        = CNT_W'(fm_q) * CNT_W'(fm_q);
  assign stream_last = area - CNT_W'(1);
  assign wd_last     = WD_W'(TIMEOUT_MULT) * WD_W'(area) - WD_W'(1);
  assign too_small   = 32'(bus.cfg_featmap_size) < KERNEL_SIZE;

  always_comb begin
    state_d = state_q;
    fm_d    = fm_q;
    last_d  = last_q;
    cls_d   = cls_q;
    err_d   = err_q;
    pass_d  = pass_q;
    cnt_d   = cnt_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          fm_d   = bus.cfg_featmap_size;
          last_d = (bus.cfg_num_passes == '0) ? '0 : bus.cfg_num_passes - PASS_W'(1);
          cls_d  = ~bus.cfg_bias_mode;
          pass_d = '0;
          cnt_d  = '0;
          wd_d   = '0;
          err_d  = too_small;
          state_d = too_small ? S_FIN : S_LOAD_W;
        end
      end
      S_LOAD_W: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = '0;
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_STREAM: begin
        if (cnt_q == stream_last) begin
          cnt_d   = '0;
          wd_d    = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DRAIN: begin
        // Tracker completion wins over a watchdog expiry landing on the same cycle.
        if (trk_done) begin
          if (pass_q == last_q) begin
            state_d = S_FIN;
          end else begin
            pass_d  = pass_q + PASS_W'(1);
            state_d = S_LOAD_W;
          end
        end else if (wd_q == wd_last) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          wd_d = wd_q + WD_W'(1);
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      fm_q    <= '0;
      last_q  <= '0;
      cls_q   <= 1'b0;
      err_q   <= 1'b0;
      pass_q  <= '0;
      cnt_q   <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      fm_q    <= fm_d;
      last_q  <= last_d;
      cls_q   <= cls_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      cnt_q   <= cnt_d;
      wd_q    <= wd_d;
    end
  end

  assign trk_clr = (state_q == S_LOAD_W);
  assign trk_en  = (state_q == S_STREAM) || (state_q == S_DRAIN);

  conv_out_tracker #(
    .KERNEL_SIZE(KERNEL_SIZE)
  ) u_tracker (
    .clk        (clk),
    .rst        (rst),
    .clr        (trk_clr),
    .en         (trk_en),
    .pe_dout_st (bus.pe_dout_st),
    .fm         (fm_q),
    .out_valid  (bus.out_valid),
    .out_row    (bus.out_row),
    .out_col    (bus.out_col),
    .finished   (trk_done)
  );

  assign bus.busy            = (state_q != S_IDLE);
  assign bus.done            = (state_q == S_FIN);
  assign bus.err             = err_q;
  assign bus.w_rd_en         = (state_q == S_LOAD_W);
  assign bus.win_st          = (state_q == S_LOAD_W) && (cnt_q == '0);
  assign bus.d_rd_en         = (state_q == S_STREAM);
  assign bus.din_st          = (state_q == S_STREAM) && (cnt_q == '0);
  assign bus.featmap_size    = fm_q;
  assign bus.convlayer_state = cls_q;
  assign bus.pass_idx        = pass_q;

endmodule

// File: tb/tb_conv_layer_seq.sv
// Directed testbench for conv_layer_seq: cycle offsets are relative to the start-pulse cycle (rel 0).
// pe_dout_st is pulsed 6 cycles after each din_st; expected values are hand-computed constants.
module tb_conv_layer_seq;
  localparam int unsigned PW = 6;

  logic clk = 1'b0;
  logic rst;

  conv_layer_seq_if #(.PASS_W(PW)) bus ();

  conv_layer_seq #(
    .KERNEL_SIZE  (3),
    .PASS_W       (PW),
    .TIMEOUT_MULT (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int rel;
  int win_cnt, win_first, w_cnt, w_first, w_last;
  int din_cnt, din_first, d_cnt, d_first, d_last, din_rel;
  int v_cnt, v_first;
  int vrow[64];
  int vcol[64];
  int vpass[64];
  int win_pass[8];
  int done_cnt, done_rel, done_err, err_rise, busy_last;
  bit dout_en, junk_start;

  function automatic logic [29:0] outs();
    return {bus.busy, bus.done, bus.err, bus.win_st, bus.w_rd_en, bus.din_st, bus.d_rd_en,
            bus.featmap_size, bus.convlayer_state, bus.pass_idx, bus.out_valid, bus.out_row, bus.out_col};
  endfunction

  task automatic clear_log();
    win_cnt = 0; win_first = -1; w_cnt = 0; w_first = -1; w_last = -1;
    din_cnt = 0; din_first = -1; d_cnt = 0; d_first = -1; d_last = -1; din_rel = -1000;
    v_cnt = 0; v_first = -1; done_cnt = 0; done_rel = -1; done_err = -1; err_rise = -1; busy_last = -1;
  endtask

  task automatic sample();
    if (bus.win_st) begin
      if (win_cnt < 8) win_pass[win_cnt] = int'(bus.pass_idx);
      win_cnt++;
      if (win_first < 0) win_first = rel;
    end
    if (bus.w_rd_en) begin w_cnt++; if (w_first < 0) w_first = rel; w_last = rel; end
    if (bus.din_st) begin din_cnt++; din_rel = rel; if (din_first < 0) din_first = rel; end
    if (bus.d_rd_en) begin d_cnt++; if (d_first < 0) d_first = rel; d_last = rel; end
    if (bus.out_valid) begin
      if (v_cnt < 64) begin
        vrow[v_cnt] = int'(bus.out_row); vcol[v_cnt] = int'(bus.out_col); vpass[v_cnt] = int'(bus.pass_idx);
      end
      if (v_first < 0) v_first = rel;
      v_cnt++;
    end
    if (bus.done) begin done_cnt++; done_rel = rel; done_err = int'(bus.err); end
    if (bus.err && err_rise < 0) err_rise = rel;
    if (bus.busy) busy_last = rel;
  endtask

  task automatic drive();
    bus.pe_dout_st = dout_en && (rel == din_rel + 6);
    bus.start      = junk_start && (rel == 5 || rel == 20);
  endtask

  task automatic launch(input logic [4:0] fm, input logic [5:0] np, input logic bm, input bit dout, input bit junk);
    @(posedge clk); #1;
    clear_log();
    dout_en = dout; junk_start = junk; rel = 0;
    bus.cfg_featmap_size = fm; bus.cfg_num_passes = np; bus.cfg_bias_mode = bm;
    bus.pe_dout_st = 1'b0; bus.start = 1'b1;
    @(negedge clk); sample();
    @(posedge clk); #1; rel = 1;
    if (junk) begin bus.cfg_featmap_size = 5'd2; bus.cfg_num_passes = 6'd3; bus.cfg_bias_mode = ~bm; end
    drive();
    @(negedge clk); sample();
  endtask

  task automatic step();
    @(posedge clk); #1; rel++; drive();
    @(negedge clk); sample();
  endtask

  task automatic run_to_done(input int budget);
    while (done_cnt == 0 && rel < budget) step();
    repeat (4) step();
  endtask

  function automatic int pos_errors(input int per_pass);
    int bad = 0;
    for (int i = 0; i < v_cnt && i < 64; i++) begin
      if (vpass[i] != i / per_pass || vrow[i] != (i % per_pass) / 3 || vcol[i] != (i % per_pass) % 3) bad++;
    end
    return bad;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0; bus.cfg_featmap_size = '0; bus.cfg_num_passes = '0; bus.cfg_bias_mode = 1'b0; bus.pe_dout_st = 1'b0;
    dout_en = 1'b0; junk_start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (outs() !== 30'd0) begin n_bad++; $display("FAIL reset_outputs: got %h want 0", outs()); end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_single_pass();
    int pb;
    launch(5'd5, 6'd1, 1'b1, 1'b1, 1'b0);
    run_to_done(300);
    pb = pos_errors(9);
    n_cmp++; if (done_cnt !== 1)   begin n_bad++; $display("FAIL single_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (done_rel !== 42)  begin n_bad++; $display("FAIL single_done_rel: got %0d want 42", done_rel); end
    n_cmp++; if (win_cnt !== 1)    begin n_bad++; $display("FAIL single_win_cnt: got %0d want 1", win_cnt); end
    n_cmp++; if (win_first !== 1)  begin n_bad++; $display("FAIL single_win_first: got %0d want 1", win_first); end
    n_cmp++; if (w_cnt !== 9)      begin n_bad++; $display("FAIL single_w_cnt: got %0d want 9", w_cnt); end
    n_cmp++; if (w_first !== 1 || w_last !== 9) begin n_bad++; $display("FAIL single_w_span: got %0d..%0d want 1..9", w_first, w_last); end
    n_cmp++; if (din_cnt !== 1 || din_first !== 10) begin n_bad++; $display("FAIL single_din_st: got cnt %0d at %0d want 1 at 10", din_cnt, din_first); end
    n_cmp++; if (d_cnt !== 25)     begin n_bad++; $display("FAIL single_d_cnt: got %0d want 25", d_cnt); end
    n_cmp++; if (d_first !== 10 || d_last !== 34) begin n_bad++; $display("FAIL single_d_span: got %0d..%0d want 10..34", d_first, d_last); end
    n_cmp++; if (v_cnt !== 9)      begin n_bad++; $display("FAIL single_valid_cnt: got %0d want 9", v_cnt); end
    n_cmp++; if (v_first !== 17)   begin n_bad++; $display("FAIL single_valid_first: got %0d want 17", v_first); end
    n_cmp++; if (pb !== 0)         begin n_bad++; $display("FAIL single_positions: got %0d bad want 0", pb); end
    n_cmp++; if (busy_last !== 42) begin n_bad++; $display("FAIL single_busy_last: got %0d want 42", busy_last); end
    n_cmp++; if (done_err !== 0)   begin n_bad++; $display("FAIL single_err: got %0d want 0", done_err); end
    n_cmp++; if (bus.convlayer_state !== 1'b0) begin n_bad++; $display("FAIL single_cls: got %0d want 0", bus.convlayer_state); end
    n_cmp++; if (bus.featmap_size !== 5'd5) begin n_bad++; $display("FAIL single_fm: got %0d want 5", bus.featmap_size); end
  endtask

  task automatic test_multi_pass();
    int pb;
    launch(5'd5, 6'd3, 1'b1, 1'b1, 1'b0);
    run_to_done(400);
    pb = pos_errors(9);
    n_cmp++; if (done_cnt !== 1)   begin n_bad++; $display("FAIL multi_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (done_rel !== 124) begin n_bad++; $display("FAIL multi_done_rel: got %0d want 124", done_rel); end
    n_cmp++; if (win_cnt !== 3 || w_cnt !== 27) begin n_bad++; $display("FAIL multi_weights: got %0d/%0d want 3/27", win_cnt, w_cnt); end
    n_cmp++; if (din_cnt !== 3 || d_cnt !== 75) begin n_bad++; $display("FAIL multi_pixels: got %0d/%0d want 3/75", din_cnt, d_cnt); end
    n_cmp++; if (v_cnt !== 27)     begin n_bad++; $display("FAIL multi_valid_cnt: got %0d want 27", v_cnt); end
    n_cmp++; if (pb !== 0)         begin n_bad++; $display("FAIL multi_positions: got %0d bad want 0", pb); end
    n_cmp++; if (win_pass[0] !== 0 || win_pass[1] !== 1 || win_pass[2] !== 2) begin
      n_bad++; $display("FAIL multi_pass_idx: got %0d,%0d,%0d want 0,1,2", win_pass[0], win_pass[1], win_pass[2]);
    end
    n_cmp++; if (bus.pass_idx !== 6'd2) begin n_bad++; $display("FAIL multi_pass_hold: got %0d want 2", bus.pass_idx); end
  endtask

  task automatic test_timeout();
    launch(5'd5, 6'd1, 1'b1, 1'b0, 1'b0);
    run_to_done(300);
    n_cmp++; if (done_cnt !== 1)  begin n_bad++; $display("FAIL timeout_done_cnt: got %0d want 1", done_cnt); end
    n_cmp++; if (done_rel !== 85) begin n_bad++; $display("FAIL timeout_done_rel: got %0d want 85", done_rel); end
    n_cmp++; if (err_rise !== 85) begin n_bad++; $display("FAIL timeout_err_rise: got %0d want 85", err_rise); end
    n_cmp++; if (done_err !== 1)  begin n_bad++; $display("FAIL timeout_err_at_done: got %0d want 1", done_err); end
    n_cmp++; if (v_cnt !== 0)     begin n_bad++; $display("FAIL timeout_valid_cnt: got %0d want 0", v_cnt); end
    launch(5'd5, 6'd1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL timeout_err_clear: got %0d want 0", bus.err); end
    run_to_done(300);
    n_cmp++; if (done_rel !== 42 || done_err !== 0) begin n_bad++; $display("FAIL timeout_rerun: got done %0d err %0d want 42 0", done_rel, done_err); end
  endtask

  task automatic test_small_map();
    launch(5'd2, 6'd1, 1'b1, 1'b1, 1'b0);
    run_to_done(20);
    n_cmp++; if (done_cnt !== 1 || done_rel !== 1) begin n_bad++; $display("FAIL small_done: got cnt %0d at %0d want 1 at 1", done_cnt, done_rel); end
    n_cmp++; if (done_err !== 1)  begin n_bad++; $display("FAIL small_err: got %0d want 1", done_err); end
    n_cmp++; if (win_cnt + w_cnt + din_cnt + d_cnt !== 0) begin
      n_bad++; $display("FAIL small_no_fetch: got %0d strobes want 0", win_cnt + w_cnt + din_cnt + d_cnt);
    end
    n_cmp++; if (busy_last !== 1) begin n_bad++; $display("FAIL small_busy_last: got %0d want 1", busy_last); end
    n_cmp++; if (bus.err !== 1'b1) begin n_bad++; $display("FAIL small_err_sticky: got %0d want 1", bus.err); end
  endtask

  task automatic test_busy_ignore();
    launch(5'd5, 6'd1, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (bus.err !== 1'b0) begin n_bad++; $display("FAIL ignore_err_clear: got %0d want 0", bus.err); end
    run_to_done(300);
    n_cmp++; if (done_cnt !== 1 || done_rel !== 42) begin n_bad++; $display("FAIL ignore_done: got cnt %0d at %0d want 1 at 42", done_cnt, done_rel); end
    n_cmp++; if (win_cnt !== 1 || v_cnt !== 9) begin n_bad++; $display("FAIL ignore_counts: got win %0d valid %0d want 1 9", win_cnt, v_cnt); end
    n_cmp++; if (bus.featmap_size !== 5'd5) begin n_bad++; $display("FAIL ignore_fm: got %0d want 5", bus.featmap_size); end
    n_cmp++; if (bus.convlayer_state !== 1'b1) begin n_bad++; $display("FAIL ignore_cls: got %0d want 1", bus.convlayer_state); end
    n_cmp++; if (bus.pass_idx !== 6'd0) begin n_bad++; $display("FAIL ignore_pass: got %0d want 0", bus.pass_idx); end
  endtask

  task automatic test_reset_mid();
    launch(5'd5, 6'd1, 1'b1, 1'b1, 1'b0);
    while (rel < 20) step();
    n_cmp++; if (bus.d_rd_en !== 1'b1) begin n_bad++; $display("FAIL midrst_in_stream: got d_rd_en %0d want 1", bus.d_rd_en); end
    rst = 1'b1;
    #1;
    n_cmp++; if (outs() !== 30'd0) begin n_bad++; $display("FAIL midrst_outputs: got %h want 0", outs()); end
    repeat (5) step();
    n_cmp++; if (done_cnt !== 0) begin n_bad++; $display("FAIL midrst_no_done: got %0d want 0", done_cnt); end
    rst = 1'b0;
    launch(5'd5, 6'd1, 1'b1, 1'b1, 1'b0);
    run_to_done(300);
    n_cmp++; if (done_cnt !== 1 || done_rel !== 42) begin n_bad++; $display("FAIL midrst_rerun_done: got cnt %0d at %0d want 1 at 42", done_cnt, done_rel); end
    n_cmp++; if (v_cnt !== 9) begin n_bad++; $display("FAIL midrst_rerun_valid: got %0d want 9", v_cnt); end
  endtask

  initial begin
    test_reset();
    test_single_pass();
    test_multi_pass();
    test_timeout();
    test_small_map();
    test_busy_ignore();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
- Sequences one convolution layer through the PE-array datapath (PE_Num parallel ConvPEs plus bias adders).
- Per output-channel pass, the block:
  - drives the weight-load phase (win_st plus a weight fetch strobe),
  - then streams the input feature map (din_st plus a pixel fetch strobe),
  - then tracks the raster position of the returned PE output stream and flags which outputs are valid convolution results.
- Repeats for a configured number of passes, then signals done. Sits between the layer-level top controller and the PE array.

Parameters:
- KERNEL_SIZE, 3, convolution kernel edge; weight load length is KERNEL_SIZE*KERNEL_SIZE cycles.
- PASS_W, 6, width of pass counter and cfg_num_passes.
- TIMEOUT_MULT, 2, drain watchdog limit = TIMEOUT_MULT*fm*fm cycles.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begin layer (ignored while busy)
- cfg_featmap_size  in  5  input map edge fm; latched at accepted start
- cfg_num_passes  in  PASS_W  number of output-channel groups; 0 treated as 1; latched at start
- cfg_bias_mode  in  1  1 = add bias; latched at start
- pe_dout_st  in  1  PE-array output-start flag
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse at layer end
- err  out  1  sticky error, cleared by next accepted start
- win_st  out  1  pulse, first weight-load cycle
- w_rd_en  out  1  weight fetch strobe, one per weight
- din_st  out  1  pulse, first pixel cycle
- d_rd_en  out  1  pixel fetch strobe, one per pixel
- featmap_size  out  5  latched fm, to PE array
- convlayer_state  out  1  0 when bias mode (bias-added output), 1 otherwise
- pass_idx  out  PASS_W  current pass, for weight/bias/output addressing
- out_valid  out  1  current PE output is a valid convolution result
- out_row  out  5  output row of out_valid sample
- out_col  out  5  output column of out_valid sample

Behaviour:
- Reset values: all outputs 0, FSM in IDLE. Reset mid-operation aborts immediately; no done pulse.
- FSM states: IDLE, LOAD_W, STREAM, DRAIN, FIN.
- IDLE:
  - On start, latch config, clear err, busy=1, pass_idx=0.
  - If fm < KERNEL_SIZE: set err and go to FIN.
  - Otherwise go to LOAD_W.
- LOAD_W:
  - Lasts KERNEL_SIZE*KERNEL_SIZE cycles, with w_rd_en=1 on every one of them.
  - win_st=1 on the first cycle only.
  - Then go to STREAM.
- STREAM:
  - Lasts fm*fm cycles, with d_rd_en=1 on every one of them.
  - din_st=1 on the first cycle only.
  - Then go to DRAIN. A pe_dout_st rise during STREAM is captured and the output tracker starts.
- Output tracker:
  - Starts on the first cycle pe_dout_st=1.
  - Raster counters r,c in 0..fm-1; c increments every cycle and wraps at fm-1, at which point r increments.
  - out_valid=1 iff r<=fm-KERNEL_SIZE and c<=fm-KERNEL_SIZE; out_row=r, out_col=c.
  - out_valid, out_row, out_col are registered and aligned to the same cycle as the PE dout sample.
  - Tracker stops after r=fm-1, c=fm-1.
- DRAIN:
  - Wait for the tracker to finish.
  - Watchdog counts DRAIN cycles. At TIMEOUT_MULT*fm*fm cycles: set err and go to FIN.
  - On tracker finish: if pass_idx == max(cfg_num_passes,1)-1 go to FIN; else pass_idx++ and go to LOAD_W.
- FIN: done=1 for one cycle, busy=0 on the next cycle, go to IDLE.
- start while busy is ignored; it does not queue.
- The number of out_valid pulses per pass is exactly (fm-KERNEL_SIZE+1)^2.
- featmap_size and convlayer_state hold their latched values until the next accepted start.
- Width rules:
  - fm*fm fits in 10 bits.
  - The watchdog counter is 11 + log2(TIMEOUT_MULT) bits.
  - All counters are unsigned.

Decomposition:
- Shared package: FSM state encoding and the localparam KK = KERNEL_SIZE*KERNEL_SIZE.
- One natural sub-module: conv_out_tracker. It owns the raster counters r,c, out_valid/out_row/out_col, and the tracker-finished flag.

Test Plan:
- fm=5, passes=1, start at cycle 0:
  - win_st at cycle 1; w_rd_en on cycles 1-9.
  - din_st at cycle 10; d_rd_en on cycles 10-34.
  - pe_dout_st driven at cycle 16 gives 9 out_valid pulses with (row,col) = (0..2, 0..2).
  - done pulse once at tracker finish + 1.
- fm=5, passes=3 → three LOAD_W/STREAM sequences; pass_idx 0,1,2; 27 out_valid total; exactly one done.
- fm=2 (< KERNEL_SIZE) → err=1 and done within 2 cycles; no win_st, din_st or rd_en activity.
- pe_dout_st held 0, fm=5 → err=1 after 50 DRAIN cycles, then a done pulse; next start clears err.
- rst asserted mid-STREAM → all outputs 0 immediately; no done; new start after release runs a normal layer.
- start pulsed while busy → ignored; pass count and done timing unchanged. cfg_bias_mode=0 → convlayer_state=1.
